agu_lsq_buffer: RTL and testbench
=================================

# agu_lsq_buffer

In-order buffer between the load/store address adder and the load/store queue. Captures each computed address packet (effective address, store data, ROB index, memory op, branch dependency tags) and presents them to the LSQ strictly in issue order under a valid/ready handshake. It absorbs LSQ backpressure, so the adder never stalls. It also squashes entries on a branch-recovery flush and clears dependency bits when a branch resolves correctly.

## Interface
Parameters:
- DEPTH, 4: entry count, power of two, ≥2
- ROB_IDX_W, 6: ROB tag width ($clog2(ROB_DEPTH)+1)
- EBR_NUM, 4: number of branch-dependency slots
- EBR_IDX_W, 2: $clog2(EBR_NUM)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  adder packet valid
- in_ready  out  1  buffer can accept
- in_addr  in  32  effective address (a + imm)
- in_wdata  in  32  store data (src_2_v)
- in_rob_idx  in  ROB_IDX_W  ROB tag of the memory op
- in_is_store  in  1  1 = store, 0 = load
- in_funct3  in  3  access size/sign
- in_dep_valid  in  EBR_NUM  dependency slot valid bits
- in_dep_tags  in  EBR_NUM*ROB_IDX_W  dependency ROB tags; slot k at bits [k*ROB_IDX_W +: ROB_IDX_W]
- out_valid, out_addr, out_wdata, out_rob_idx, out_is_store, out_funct3, out_dep_valid, out_dep_tags  out  as inputs  head packet
- out_ready  in  1  LSQ accepts head
- flush  in  1  branch-recovery squash
- recover_idx  in  EBR_IDX_W  dependency slot being recovered
- depen_rob  in  ROB_IDX_W  ROB tag of the mispredicted branch
- resolve_valid  in  1  branch resolved correctly
- resolve_idx  in  EBR_IDX_W  slot to release
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Collapsing queue: slot 0 is the oldest entry. Entry order always equals acceptance order.
- Squash match for a packet: `flush && dep_valid[recover_idx] && dep_tags[recover_idx] == depen_rob`.
- Each cycle, the next state is computed in this order:
  1. Remove the head if the handshake fired (out_valid && out_ready).
  2. Remove every squash-matching entry.
  3. Append the incoming packet if in_valid && in_ready and it does not squash-match.
  4. Compact the surviving entries toward slot 0.
- Resolve: when resolve_valid is high, clear dep_valid[resolve_idx] in every stored entry and in the incoming packet before it is stored.
  - If resolve_idx == recover_idx with flush and resolve_valid both high, squash is evaluated on pre-resolve bits.
- in_ready = (count < DEPTH). It is registered-state only and does not depend on out_ready.
- out_valid = slot0 valid && !squash_match(slot0). A squashed head is never handed to the LSQ.
- When out_valid is low, out_* data fields are don't-care, but they must be driven from slot 0, never X.

## Timing
- Reset, asserted asynchronously:
  - all entry valid bits = 0, count = 0
  - out_valid = 0, in_ready = 1
  - stored data is cleared to 0
- Reset asserted mid-operation discards all entries immediately. Nothing is emitted after deassertion until new input arrives.
- Latency: a packet accepted in cycle N is presented with out_valid = 1 in cycle N+1 at the earliest (except in bypass mode, see Configuration).
- Throughput: one accept and one emit per cycle, sustained.
- Full (count = DEPTH): in_ready = 0 for that cycle, even if out_ready = 1. Only registered count gates input.
- Empty: out_valid = 0.
- Simultaneous events:
  - Accept, emit and squash in one cycle resolve per the Operation order.
  - count reflects the next state one cycle later.

## Configuration
- AGU_BUF_BYPASS_EN defined:
  - When count = 0, in_valid = 1, the incoming packet does not squash-match, and out_ready = 1, the packet drives out_* combinationally.
  - out_valid = 1 in the same cycle, and the packet is not stored. This gives 0-cycle latency.
  - Otherwise behaviour is as below.
- Not defined: no combinational in→out path; minimum latency is 1 cycle.

## Test plan
- Reset then fill:
  - Assert rst low mid-stream with 3 entries held → count = 0, out_valid = 0 immediately.
  - After release, push addrs 0x100, 0x104, 0x108, 0x10C with out_ready = 0 → count = 4, in_ready = 0, head out_addr = 0x100.
- Ordering under backpressure:
  - Toggle out_ready 1/0 while streaming 8 packets → LSQ receives addrs in exact push order with no duplicates.
- Flush squash:
  - Entries A (dep slot 1 tag 5 valid), B (slot 1 tag 6), C (slot 1 tag 5).
  - flush with recover_idx = 1, depen_rob = 5 → only B remains, at head, count = 1 next cycle.
  - A is not emitted in the flush cycle even if out_ready = 1.
- Flush plus incoming:
  - flush matches the incoming packet in the same cycle as in_valid → packet dropped, count unchanged.
- Resolve:
  - resolve_valid, resolve_idx = 2 with 3 entries having dep_valid = 4'b0100 → all out_dep_valid = 4'b0000.
  - A later flush with recover_idx = 2 squashes none.
- Bypass (AGU_BUF_BYPASS_EN):
  - Empty buffer, in_valid = 1, out_ready = 1, addr 0x2000 → out_valid = 1 with out_addr = 0x2000 in the same cycle, count stays 0.
  - Without the macro → out_valid = 1 one cycle later and count = 1 for that cycle.

Source files
------------

// File: rtl/agu_lsq_buffer.sv
// agu_lsq_buffer
//   In-order collapsing buffer between the load/store address adder and the
//   load/store queue. Slot 0 always holds the oldest packet. Entries are
//   squashed on a branch-recovery flush and have dependency bits cleared when
//   a branch resolves correctly.
//
// Optional feature: define AGU_BUF_BYPASS_EN to let an incoming packet reach
//   out_* combinationally when the buffer is empty and the LSQ is ready.
//
// Ports
//   clk, rst                 clock / asynchronous active-low reset
//   in_valid, in_ready       adder-side handshake
//   in_addr .. in_dep_tags   incoming packet fields
//   out_valid, out_ready     LSQ-side handshake
//   out_addr .. out_dep_tags head packet fields (driven from slot 0)
//   flush, recover_idx, depen_rob     squash request
//   resolve_valid, resolve_idx        dependency-slot release
//   count                    registered occupancy
module agu_lsq_buffer #(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 6,
    parameter int EBR_NUM   = 4,
    parameter int EBR_IDX_W = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_addr,
    input  logic [31:0]                    in_wdata,
    input  logic [ROB_IDX_W-1:0]           in_rob_idx,
    input  logic                           in_is_store,
    input  logic [2:0]                     in_funct3,
    input  logic [EBR_NUM-1:0]             in_dep_valid,
    input  logic [EBR_NUM*ROB_IDX_W-1:0]   in_dep_tags,
    output logic                           out_valid,
    output logic [31:0]                    out_addr,
    output logic [31:0]                    out_wdata,
    output logic [ROB_IDX_W-1:0]           out_rob_idx,
    output logic                           out_is_store,
    output logic [2:0]                     out_funct3,
    output logic [EBR_NUM-1:0]             out_dep_valid,
    output logic [EBR_NUM*ROB_IDX_W-1:0]   out_dep_tags,
    input  logic                           out_ready,
    input  logic                           flush,
    input  logic [EBR_IDX_W-1:0]           recover_idx,
    input  logic [ROB_IDX_W-1:0]           depen_rob,
    input  logic                           resolve_valid,
    input  logic [EBR_IDX_W-1:0]           resolve_idx,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]                  addr;
        logic [31:0]                  wdata;
        logic [ROB_IDX_W-1:0]         rob_idx;
        logic                         is_store;
        logic [2:0]                   funct3;
        logic [EBR_NUM-1:0]           dep_valid;
        logic [EBR_NUM*ROB_IDX_W-1:0] dep_tags;
    } pkt_t;

    pkt_t             ent_q [DEPTH];
    pkt_t             ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    pkt_t               in_pkt, in_pkt_r, out_pkt;
    logic               in_sq, head_ok, fire, byp;
    logic [EBR_NUM-1:0] res_keep;

    // Squash test always uses the stored (pre-resolve) dependency bits.
    function automatic logic sq_match(input logic fl,
                                      input logic [EBR_IDX_W-1:0] ri,
                                      input logic [ROB_IDX_W-1:0] dr,
                                      input pkt_t p);
        return fl && p.dep_valid[ri] &&
               (p.dep_tags[int'(ri)*ROB_IDX_W +: ROB_IDX_W] == dr);
    endfunction

    always_comb begin
        res_keep = '1;
        if (resolve_valid) res_keep[resolve_idx] = 1'b0;
    end

    always_comb begin
        in_pkt.addr      = in_addr;
        in_pkt.wdata     = in_wdata;
        in_pkt.rob_idx   = in_rob_idx;
        in_pkt.is_store  = in_is_store;
        in_pkt.funct3    = in_funct3;
        in_pkt.dep_valid = in_dep_valid;
        in_pkt.dep_tags  = in_dep_tags;
        in_pkt_r           = in_pkt;
        in_pkt_r.dep_valid = in_dep_valid & res_keep;
    end

    assign in_sq    = sq_match(flush, recover_idx, depen_rob, in_pkt);
    assign head_ok  = vld_q[0] && !sq_match(flush, recover_idx, depen_rob, ent_q[0]);
    assign in_ready = (cnt_q < CW'(DEPTH));
    assign count    = cnt_q;

`ifdef AGU_BUF_BYPASS_EN
    assign byp = (cnt_q == '0) && in_valid && !in_sq && out_ready;
`else
    assign byp = 1'b0;
`endif

    assign fire      = head_ok && out_ready;
    assign out_valid = head_ok || byp;
    assign out_pkt   = byp ? in_pkt_r : ent_q[0];

    assign out_addr      = out_pkt.addr;
    assign out_wdata     = out_pkt.wdata;
    assign out_rob_idx   = out_pkt.rob_idx;
    assign out_is_store  = out_pkt.is_store;
    assign out_funct3    = out_pkt.funct3;
    assign out_dep_valid = out_pkt.dep_valid;
    assign out_dep_tags  = out_pkt.dep_tags;

    // Pop, squash, append and compaction folded into one pass: survivors are
    // written to the next free slot in age order, then the new packet lands
    // behind them. Unused slots are zeroed so slot 0 is never X.
    always_comb begin
        logic [CW-1:0] n;
        n     = '0;
        vld_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) ent_d[i] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !sq_match(flush, recover_idx, depen_rob, ent_q[i])
                && !(i == 0 && fire)) begin
                ent_d[n[CW-2:0]]           = ent_q[i];
                ent_d[n[CW-2:0]].dep_valid = ent_q[i].dep_valid & res_keep;
                vld_d[n[CW-2:0]]           = 1'b1;
                n                          = n + CW'(1);
            end
        end
        if (in_valid && in_ready && !in_sq && !byp && (n < CW'(DEPTH))) begin
            ent_d[n[CW-2:0]] = in_pkt_r;
            vld_d[n[CW-2:0]] = 1'b1;
            n                = n + CW'(1);
        end
        cnt_d = n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

endmodule

// File: tb/tb_agu_lsq_buffer.sv
module tb_agu_lsq_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_addr, in_wdata;
    logic [5:0]  in_rob_idx;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [3:0]  in_dep_valid;
    logic [23:0] in_dep_tags;
    logic        out_valid;
    logic [31:0] out_addr, out_wdata;
    logic [5:0]  out_rob_idx;
    logic        out_is_store;
    logic [2:0]  out_funct3;
    logic [3:0]  out_dep_valid;
    logic [23:0] out_dep_tags;
    logic        out_ready, flush, resolve_valid;
    logic [1:0]  recover_idx, resolve_idx;
    logic [5:0]  depen_rob;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    agu_lsq_buffer #(.DEPTH(4), .ROB_IDX_W(6), .EBR_NUM(4), .EBR_IDX_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rob_idx(in_rob_idx),
        .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_dep_valid(in_dep_valid), .in_dep_tags(in_dep_tags),
        .out_valid(out_valid), .out_addr(out_addr), .out_wdata(out_wdata),
        .out_rob_idx(out_rob_idx), .out_is_store(out_is_store),
        .out_funct3(out_funct3), .out_dep_valid(out_dep_valid),
        .out_dep_tags(out_dep_tags), .out_ready(out_ready),
        .flush(flush), .recover_idx(recover_idx), .depen_rob(depen_rob),
        .resolve_valid(resolve_valid), .resolve_idx(resolve_idx),
        .count(count)
    );

    typedef struct {
        bit          iv;
        logic [31:0] a;
        logic [3:0]  dv;
        logic [5:0]  tg;
        bit          ordy;
        bit          fl;
        logic [1:0]  ri;
        logic [5:0]  dr;
        bit          rv;
        logic [1:0]  rx;
        bit          e_ov;
        logic [31:0] e_oa;
        logic [3:0]  e_odv;
        logic [2:0]  e_cnt;
        bit          e_ir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit iv, logic [31:0] a, logic [3:0] dv, logic [5:0] tg,
                                bit ordy, bit fl, logic [1:0] ri, logic [5:0] dr,
                                bit rv, logic [1:0] rx, bit e_ov, logic [31:0] e_oa,
                                logic [3:0] e_odv, logic [2:0] e_cnt, bit e_ir);
        vec_t v;
        v.iv = iv; v.a = a; v.dv = dv; v.tg = tg; v.ordy = ordy; v.fl = fl;
        v.ri = ri; v.dr = dr; v.rv = rv; v.rx = rx; v.e_ov = e_ov; v.e_oa = e_oa;
        v.e_odv = e_odv; v.e_cnt = e_cnt; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_addr = '0; in_wdata = '0; in_rob_idx = '0;
        in_is_store = 0; in_funct3 = '0; in_dep_valid = '0; in_dep_tags = '0;
        out_ready = 0; flush = 0; recover_idx = '0; depen_rob = '0;
        resolve_valid = 0; resolve_idx = '0;
    endtask

    task automatic drive(input vec_t v);
        in_valid = v.iv; in_addr = v.a; in_wdata = ~v.a;
        in_dep_valid = v.dv; in_dep_tags = {4{v.tg}};
        out_ready = v.ordy; flush = v.fl; recover_idx = v.ri; depen_rob = v.dr;
        resolve_valid = v.rv; resolve_idx = v.rx;
    endtask

    initial begin
        int unsigned sent, rcvd, cyc;
        logic [31:0] expq[$];
        logic [31:0] e;

        idle_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_count", 32'(count), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_data_zero", out_addr, 0);
        @(negedge clk);
        rst = 1;

        // iv a dv tg | or fl ri dr rv rx | e_ov e_oa e_odv e_cnt e_ir
        tbl.push_back(mk(1, 32'h100, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'b0000, 0, 1));
        tbl.push_back(mk(1, 32'h104, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 4'b0000, 1, 1));
        tbl.push_back(mk(1, 32'h108, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 4'b0000, 2, 1));
        tbl.push_back(mk(1, 32'h10C, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 4'b0000, 3, 1));
        tbl.push_back(mk(1, 32'h110, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 4'b0000, 4, 0));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h100, 4'b0000, 4, 0));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h104, 4'b0000, 3, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h108, 4'b0000, 2, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h10C, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'b0000, 0, 1));
        // flush squash: A(tag5) B(tag6) C(tag5) on slot 1
        tbl.push_back(mk(1, 32'h200, 4'b0010, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'b0000, 0, 1));
        tbl.push_back(mk(1, 32'h204, 4'b0010, 6, 0, 0, 0, 0, 0, 0, 1, 32'h200, 4'b0010, 1, 1));
        tbl.push_back(mk(1, 32'h208, 4'b0010, 5, 0, 0, 0, 0, 0, 0, 1, 32'h200, 4'b0010, 2, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 1, 1, 5, 0, 0, 0, 32'h0,   4'b0000, 3, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h204, 4'b0010, 1, 1));
        // flush matching the incoming packet
        tbl.push_back(mk(1, 32'h20C, 4'b0010, 5, 0, 1, 1, 5, 0, 0, 1, 32'h204, 4'b0010, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h204, 4'b0010, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h204, 4'b0010, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'b0000, 0, 1));
        // resolve slot 2 on stored entries, then flush on slot 2 squashes none
        tbl.push_back(mk(1, 32'h300, 4'b0100, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'b0000, 0, 1));
        tbl.push_back(mk(1, 32'h304, 4'b0100, 9, 0, 0, 0, 0, 0, 0, 1, 32'h300, 4'b0100, 1, 1));
        tbl.push_back(mk(1, 32'h308, 4'b0100, 9, 0, 0, 0, 0, 0, 0, 1, 32'h300, 4'b0100, 2, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 1, 2, 1, 32'h300, 4'b0100, 3, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 4'b0000, 3, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 1, 2, 9, 0, 0, 1, 32'h300, 4'b0000, 3, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 4'b0000, 3, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h300, 4'b0000, 3, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h304, 4'b0000, 2, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h308, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'b0000, 0, 1));
        // resolve applied to the incoming packet
        tbl.push_back(mk(1, 32'h400, 4'b0100, 9, 0, 0, 0, 0, 1, 2, 0, 32'h0,   4'b0000, 0, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 1, 2, 9, 0, 0, 1, 32'h400, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h400, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'b0000, 0, 1));
        // accept + emit + squash together: D emitted, E squashed, F appended
        tbl.push_back(mk(1, 32'h500, 4'b0010, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'b0000, 0, 1));
        tbl.push_back(mk(1, 32'h504, 4'b0010, 7, 0, 0, 0, 0, 0, 0, 1, 32'h500, 4'b0010, 1, 1));
        tbl.push_back(mk(1, 32'h508, 4'b0000, 0, 1, 1, 1, 7, 0, 0, 1, 32'h500, 4'b0010, 2, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h508, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h508, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 32'h0,   4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'b0000, 0, 1));

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k]);
            #1;
            chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
            chk($sformatf("v%0d_count", k), 32'(count), 32'(tbl[k].e_cnt));
            chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].e_ir));
            if (tbl[k].e_ov) begin
                chk($sformatf("v%0d_out_addr", k), out_addr, tbl[k].e_oa);
                chk($sformatf("v%0d_out_dep_valid", k), 32'(out_dep_valid), 32'(tbl[k].e_odv));
            end
        end

        // Mid-stream asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            in_valid = 1; in_addr = 32'h600 + 32'(i);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("pre_reset_count", 32'(count), 3);
        #2 rst = 0;
        #1;
        chk("async_reset_count", 32'(count), 0);
        chk("async_reset_out_valid", 32'(out_valid), 0);
        chk("async_reset_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        out_ready = 1;
        #1;
        chk("post_reset_out_valid", 32'(out_valid), 0);

        // Streaming 8 packets with out_ready toggling
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 8 && cyc < 100) begin
            @(negedge clk);
            idle_inputs();
            in_valid  = (sent < 8);
            in_addr   = 32'h1000 + 32'(sent) * 4;
            out_ready = cyc[0];
            #1;
            if (in_valid && in_ready) begin
                expq.push_back(in_addr);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("stream_unexpected_emit", out_addr, 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("stream_order_%0d", rcvd), out_addr, e);
                end
                rcvd++;
            end
            cyc++;
        end
        chk("stream_received", rcvd, 8);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("stream_drained_valid", 32'(out_valid), 0);
        chk("stream_drained_count", 32'(count), 0);

        // Empty buffer, in_valid and out_ready together
        @(negedge clk);
        idle_inputs();
        in_valid = 1; in_addr = 32'h2000; out_ready = 1;
        #1;
`ifdef AGU_BUF_BYPASS_EN
        chk("bypass_out_valid", 32'(out_valid), 1);
        chk("bypass_out_addr", out_addr, 32'h2000);
        chk("bypass_count", 32'(count), 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("bypass_not_stored", 32'(count), 0);
        chk("bypass_no_repeat", 32'(out_valid), 0);
`else
        chk("nobypass_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        idle_inputs();
        out_ready = 1;
        #1;
        chk("nobypass_late_valid", 32'(out_valid), 1);
        chk("nobypass_late_addr", out_addr, 32'h2000);
        chk("nobypass_count", 32'(count), 1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("nobypass_drained", 32'(count), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
